// File: rtl/braid_pkg.sv
// Shared definitions for the braid mixing scheduler.
//   braid_state_e : scheduler state encoding (IDLE, ISSUE, DWELL, DONE)
//   clog2_min1    : ceil(log2(v)) with a floor of 1, so a field never
//                   collapses to zero width when a count is 1.
package braid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } braid_state_e;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/braid_partner.sv
// Combinational partner-channel selection for one braid operation.
//   ch      : channel being mixed (0..N_CH-1)
//   step    : current braid step
//   mode    : 0 = fixed partner (ch+1), 1 = partner rotates with the step
//   partner : channel mixed with ch
module braid_partner
    import braid_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int STEP_W = 5
) (
    input  logic [clog2_min1(N_CH)-1:0] ch,
    input  logic [STEP_W-1:0]           step,
    input  logic                        mode,
    output logic [clog2_min1(N_CH)-1:0] partner
);

    localparam int          CH_W = clog2_min1(N_CH);
    localparam logic [31:0] NCH  = 32'(N_CH);
    // The rotation uses N_CH-1 offsets so a channel is never paired with itself.
    localparam logic [31:0] NROT = 32'(N_CH - 1);

    logic [31:0] rot;
    logic [31:0] sum;

    always_comb begin
        rot     = mode ? (32'(step) % NROT) : 32'd0;
        sum     = (32'(ch) + 32'd1 + rot) % NCH;
        partner = CH_W'(sum);
    end

endmodule

// File: rtl/braid_mix_scheduler.sv
// Braid mixing scheduler: walks DEPTH steps x N_CH channels, offering one
// mixer command per operation and dwelling MIX_CYCLES after each accepted one.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, mode     : run request (accepted in IDLE only), partner mode
//   abort           : terminate an active run
//   cmd_valid/ready : mixer command handshake
//   cmd_step        : braid step of the offered command
//   cmd_ch_a/ch_b   : channel pair to mix
//   busy            : run in progress (ISSUE, DWELL, DONE)
//   done, aborted   : one-cycle completion pulses
module braid_mix_scheduler
    import braid_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEPTH      = 32,
    parameter int MIX_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         abort,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [clog2_min1(DEPTH)-1:0] cmd_step,
    output logic [clog2_min1(N_CH)-1:0]  cmd_ch_a,
    output logic [clog2_min1(N_CH)-1:0]  cmd_ch_b,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);

    localparam int STEP_W  = clog2_min1(DEPTH);
    localparam int CH_W    = clog2_min1(N_CH);
    localparam int DWELL_W = clog2_min1(MIX_CYCLES);

    braid_state_e        state_q;
    logic [STEP_W-1:0]   step_q;
    logic [CH_W-1:0]     ch_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic                mode_q;

    logic                last_ch;
    logic                last_op;
    logic                dwell_end;
    logic [CH_W-1:0]     nxt_ch;
    logic [STEP_W-1:0]   nxt_step;
    logic [CH_W-1:0]     p_ch;
    logic [STEP_W-1:0]   p_step;
    logic                p_mode;
    logic [CH_W-1:0]     partner;

    // The partner is always computed for the operation about to be issued:
    // op (0,0) with the incoming mode when starting, otherwise the successor
    // of the current op. This lets the command fields be registered.
    always_comb begin
        last_ch   = (ch_q == CH_W'(N_CH - 1));
        last_op   = last_ch && (step_q == STEP_W'(DEPTH - 1));
        dwell_end = (dwell_q == DWELL_W'(MIX_CYCLES - 1));
        nxt_ch    = last_ch ? '0 : ch_q + CH_W'(1);
        nxt_step  = last_ch ? step_q + STEP_W'(1) : step_q;
        if (state_q == ST_IDLE) begin
            p_ch   = '0;
            p_step = '0;
            p_mode = mode;
        end else begin
            p_ch   = nxt_ch;
            p_step = nxt_step;
            p_mode = mode_q;
        end
    end

    braid_partner #(
        .N_CH   (N_CH),
        .STEP_W (STEP_W)
    ) u_partner (
        .ch      (p_ch),
        .step    (p_step),
        .mode    (p_mode),
        .partner (partner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            ch_q      <= '0;
            dwell_q   <= '0;
            mode_q    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_step  <= '0;
            cmd_ch_a  <= '0;
            cmd_ch_b  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort outranks everything outside IDLE, including a handshake
            // landing on the same edge (that command counts as not taken).
            if (abort && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                cmd_valid <= 1'b0;
                busy      <= 1'b0;
                aborted   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q   <= ST_ISSUE;
                            step_q    <= '0;
                            ch_q      <= '0;
                            mode_q    <= mode;
                            cmd_valid <= 1'b1;
                            cmd_step  <= '0;
                            cmd_ch_a  <= '0;
                            cmd_ch_b  <= partner;
                            busy      <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        if (cmd_ready) begin
                            state_q   <= ST_DWELL;
                            cmd_valid <= 1'b0;
                            dwell_q   <= '0;
                        end
                    end
                    ST_DWELL: begin
                        if (dwell_end) begin
                            dwell_q <= '0;
                            if (last_op) begin
                                state_q <= ST_DONE;
                                done    <= 1'b1;
                            end else begin
                                state_q   <= ST_ISSUE;
                                step_q    <= nxt_step;
                                ch_q      <= nxt_ch;
                                cmd_valid <= 1'b1;
                                cmd_step  <= nxt_step;
                                cmd_ch_a  <= nxt_ch;
                                cmd_ch_b  <= partner;
                            end
                        end else begin
                            dwell_q <= dwell_q + DWELL_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_braid_mix_scheduler.sv
// Self-checking bench for braid_mix_scheduler (N_CH=4, DEPTH=2, MIX_CYCLES=3).
module tb_braid_mix_scheduler;

    localparam int N_CH  = 4;
    localparam int DEPTH = 2;
    localparam int MIX   = 3;
    localparam int TOTAL = N_CH * DEPTH;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic       abort;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [0:0] cmd_step;
    logic [1:0] cmd_ch_a;
    logic [1:0] cmd_ch_b;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_checks = 0;
    int n_fail   = 0;

    braid_mix_scheduler #(
        .N_CH       (N_CH),
        .DEPTH      (DEPTH),
        .MIX_CYCLES (MIX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_step  (cmd_step),
        .cmd_ch_a  (cmd_ch_a),
        .cmd_ch_b  (cmd_ch_b),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_partner(input logic md, input int s, input int c);
        if (md) return (c + 1 + (s % (N_CH - 1))) % N_CH;
        return (c + 1) % N_CH;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   32'(cmd_valid), 0);
        check({tag, "_busy"},    32'(busy),      0);
        check({tag, "_done"},    32'(done),      0);
        check({tag, "_aborted"}, 32'(aborted),   0);
        check({tag, "_step"},    32'(cmd_step),  0);
        check({tag, "_ch_a"},    32'(cmd_ch_a),  0);
        check({tag, "_ch_b"},    32'(cmd_ch_b),  0);
    endtask

    // Runs one full braid from IDLE and checks every cycle against a timeline
    // model: op k is offered from its issue cycle until accepted, the next op
    // is offered 1+MIX cycles after acceptance, done follows the last dwell.
    task automatic run_braid(input logic md, input int stall_idx, input int stall_len,
                             input bit rnd, input int busy_start);
        int   idx        = 0;
        int   cyc        = 1;
        int   next_issue = 1;
        int   stalls     = 0;
        int   held       = 0;
        int   done_cyc   = -1;
        logic rdy;
        logic exp_valid;
        logic exp_done;
        mode      = md;
        start     = 1'b1;
        cmd_ready = 1'b1;
        tick();
        start = 1'b0;
        mode  = ~md;
        while (done_cyc < 0 && cyc < 400) begin
            exp_valid = (idx < TOTAL) && (cyc >= next_issue);
            exp_done  = (idx == TOTAL) && (cyc == next_issue);
            check("cmd_valid", 32'(cmd_valid), 32'(exp_valid));
            check("busy",      32'(busy),      1);
            check("aborted",   32'(aborted),   0);
            check("done",      32'(done),      32'(exp_done));
            if (exp_valid) begin
                check("cmd_step", 32'(cmd_step), 32'(idx / N_CH));
                check("cmd_ch_a", 32'(cmd_ch_a), 32'(idx % N_CH));
                check("cmd_ch_b", 32'(cmd_ch_b), 32'(exp_partner(md, idx / N_CH, idx % N_CH)));
            end
            if (exp_done) done_cyc = cyc;
            if (rnd) rdy = 1'($urandom_range(0, 1));
            else     rdy = (exp_valid && idx == stall_idx && held < stall_len) ? 1'b0 : 1'b1;
            if (exp_valid && !rdy) begin
                stalls++;
                held++;
            end
            if (exp_valid && rdy) begin
                idx++;
                next_issue = cyc + 1 + MIX;
            end
            cmd_ready = rdy;
            start     = (cyc == busy_start);
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        start     = 1'b0;
        cmd_ready = 1'b1;
        check("done_seen",  32'(done_cyc >= 0), 1);
        check("done_cycle", 32'(done_cyc), 32'(1 + TOTAL * (1 + MIX) + stalls));
        tick();
        check("post_busy",  32'(busy),      0);
        check("post_done",  32'(done),      0);
        check("post_valid", 32'(cmd_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        abort     = 1'b0;
        cmd_ready = 1'b0;
        #3;
        check_all_zero("reset");
        #9;
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // Mode 0 and mode 1 with ready held high
        run_braid(1'b0, -1, 0, 1'b0, -1);
        run_braid(1'b1, -1, 0, 1'b0, -1);

        // Backpressure on the 3rd command for 5 cycles
        run_braid(1'b0, 2, 5, 1'b0, -1);

        // Start while busy is ignored
        run_braid(1'b1, -1, 0, 1'b0, 10);

        // Randomized backpressure
        run_braid(1'b1, -1, 0, 1'b1, -1);
        run_braid(1'b0, -1, 0, 1'b1, -1);

        // Abort during DWELL of the 4th op (issued cycle 13, dwell 14..16)
        mode      = 1'b0;
        cmd_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 14; k++) tick();
        check("abort_pre_valid", 32'(cmd_valid), 0);
        check("abort_pre_busy",  32'(busy),      1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", 32'(aborted),   1);
        check("abort_busy",  32'(busy),      0);
        check("abort_valid", 32'(cmd_valid), 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            check("abort_no_done",    32'(done),      0);
            check("abort_one_pulse",  32'(aborted),   0);
            check("abort_stay_idle",  32'(cmd_valid), 0);
        end
        run_braid(1'b1, -1, 0, 1'b0, -1);

        // Abort wins over a simultaneous handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hs_valid", 32'(cmd_valid), 1);
        cmd_ready = 1'b1;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check("hs_abort_pulse", 32'(aborted),   1);
        check("hs_abort_valid", 32'(cmd_valid), 0);
        check("hs_abort_busy",  32'(busy),      0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("hs_idle_valid", 32'(cmd_valid), 0);
            check("hs_idle_busy",  32'(busy),      0);
        end

        // Abort in IDLE ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_pulse", 32'(aborted), 0);
        check("idle_abort_busy",  32'(busy),    0);

        // Abort and start together in IDLE start the run
        mode  = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy",    32'(busy),      1);
        check("sa_valid",   32'(cmd_valid), 1);
        check("sa_aborted", 32'(aborted),   0);
        check("sa_ch_a",    32'(cmd_ch_a),  0);
        check("sa_ch_b",    32'(cmd_ch_b),  1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("sa_abort_pulse", 32'(aborted), 1);
        tick();

        // Reset mid-run discards the run silently
        mode      = 1'b1;
        cmd_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        check_all_zero("midreset_hold");
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_no_done",    32'(done),    0);
        check("rst_no_aborted", 32'(aborted), 0);
        run_braid(1'b0, -1, 0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/braid_mix_scheduler.md
BRAID_MIX_SCHEDULER -- requirements
Module: braid_mix_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of fluid channels in the braid, legal range 2..16.
REQ-002 SHALL have parameter DEPTH, default 32: number of braid steps, legal range 1..256.
REQ-003 SHALL have parameter MIX_CYCLES, default 8: dwell cycles per mixer actuation, legal range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to run a full braid.
REQ-007 SHALL have port mode, input, 1 bit: 0 = fixed partner, 1 = rotating partner; sampled on accepted start.
REQ-008 SHALL have port abort, input, 1 bit: terminate the run.
REQ-009 SHALL have port cmd_valid, output, 1 bit: mixer command offered.
REQ-010 SHALL have port cmd_ready, input, 1 bit: mixer actuator accepts the command.
REQ-011 SHALL have port cmd_step, output, clog2(DEPTH) bits (min 1): current braid step.
REQ-012 SHALL have ports cmd_ch_a and cmd_ch_b, output, clog2(N_CH) bits each: the channels to be mixed.
REQ-013 SHALL have port busy, output, 1 bit: run in progress.
REQ-014 SHALL have ports done and aborted, output, 1 bit each: one-cycle completion pulses.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, DWELL and DONE.
REQ-016 SHALL accept start only in IDLE, moving to ISSUE with step=0 and ch=0; start outside IDLE is ignored.
REQ-017 In ISSUE, SHALL drive cmd_valid=1 with cmd_step=step, cmd_ch_a=ch and cmd_ch_b=partner, holding them stable until cmd_valid&cmd_ready.
REQ-018 SHALL compute partner as (ch+1) mod N_CH in mode 0, and as (ch+1+(step mod (N_CH-1))) mod N_CH in mode 1.
REQ-019 On handshake, SHALL enter DWELL with cmd_valid=0 for exactly MIX_CYCLES cycles.
REQ-020 At the end of DWELL, SHALL advance ch; on ch wrap from N_CH-1 to 0 it SHALL advance step.
REQ-021 After the last operation (step=DEPTH-1, ch=N_CH-1), SHALL enter DONE instead of ISSUE.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 With cmd_ready held high, one operation SHALL take 1+MIX_CYCLES cycles and a run DEPTH*N_CH*(1+MIX_CYCLES) cycles.
REQ-024 Backpressure SHALL stall in ISSUE indefinitely with no loss or change of command fields.
REQ-025 busy SHALL be 1 in ISSUE, DWELL and DONE, and 0 in IDLE.
REQ-026 abort in any non-IDLE state SHALL force IDLE on the next edge, pulse aborted=1 for one cycle, drop cmd_valid, and suppress done.
REQ-027 abort in IDLE SHALL be ignored.
REQ-028 abort SHALL win over a simultaneous handshake, with the command counted as not accepted.
REQ-029 abort and start in the same cycle in IDLE SHALL start the run.
REQ-030 The step and dwell counters SHALL be sized so they never overflow at maximum parameter values.

Reset
REQ-031 On rst_n low, the state SHALL be IDLE, all counters 0, mode register 0.
REQ-032 On rst_n low, cmd_valid, busy, done, aborted, cmd_step, cmd_ch_a and cmd_ch_b SHALL all be 0.
REQ-033 Reset mid-run SHALL discard the run with no done pulse and no aborted pulse.

Structure
REQ-034 Package braid_pkg SHALL hold the state enum and width helper functions.
REQ-035 The partner computation SHALL be a sub-module braid_partner (combinational, parameter N_CH); all sequential logic stays in the top.

Verification (N_CH=4, DEPTH=2, MIX_CYCLES=3)
REQ-036 Mode 0 with ready high, start at cycle 0 -> 8 commands on cycles 1,5,...,29; pairs per step (0,1),(1,2),(2,3),(3,0); done at cycle 33.
REQ-037 Mode 1 -> step 0 pairs (0,1),(1,2),(2,3),(3,0); step 1 pairs (0,2),(1,3),(2,0),(3,1).
REQ-038 cmd_ready low for 5 cycles on the 3rd command -> fields stable throughout; done delayed exactly 5 cycles.
REQ-039 abort during DWELL of the 4th operation -> aborted pulse next cycle, busy=0, no done; a new start then begins again at step 0 ch 0.
REQ-040 rst_n low mid-run -> all outputs 0 immediately; start after release runs a full 8-command sequence.
REQ-041 start while busy -> ignored, sequence unchanged.
